// File: rtl/spi_flash_emu_if.sv
// Pin and backdoor-load bundle for spi_flash_emu; signal names match the original flat ports.
interface spi_flash_emu_if #(
    parameter int MEM_AW = 12
);
    logic              spi_sck_i;
    logic              spi_cs_ni;
    logic              spi_mosi_i;
    logic              spi_miso_o;
    logic              spi_miso_oe_o;
    logic              load_we_i;
    logic [MEM_AW-1:0] load_addr_i;
    logic [7:0]        load_data_i;
    logic              active_o;
    logic [7:0]        last_cmd_o;

    modport slave (
        input  spi_sck_i, spi_cs_ni, spi_mosi_i, load_we_i, load_addr_i, load_data_i,
        output spi_miso_o, spi_miso_oe_o, active_o, last_cmd_o
    );

    modport master (
        output spi_sck_i, spi_cs_ni, spi_mosi_i, load_we_i, load_addr_i, load_data_i,
        input  spi_miso_o, spi_miso_oe_o, active_o, last_cmd_o
    );
endinterface

// File: rtl/spi_flash_emu.sv
// SPI NOR-flash emulator, all SPI pins oversampled in clk_i (mode 0, READ/FAST READ/RDID/RDSR).
// Define SPI_FLASH_EMU_PROG_EN to add WREN/WRDI/PAGE PROGRAM.
module spi_flash_emu #(
    parameter int          MEM_AW      = 12,
    parameter int          SYNC_STAGES = 2,
    parameter logic [23:0] JEDEC_ID    = 24'hBF2541
) (
    input logic            clk_i,
    input logic            rst_i,
    spi_flash_emu_if.slave bus
);
    localparam logic [3:0] S_IDLE   = 4'd0;
    localparam logic [3:0] S_CMD    = 4'd1;
    localparam logic [3:0] S_ADDR   = 4'd2;
    localparam logic [3:0] S_DUMMY  = 4'd3;
    localparam logic [3:0] S_DATA   = 4'd4;
    localparam logic [3:0] S_ID     = 4'd5;
    localparam logic [3:0] S_STAT   = 4'd6;
    localparam logic [3:0] S_IGNORE = 4'd7;

    logic [SYNC_STAGES-1:0] sck_sync, cs_sync, mosi_sync;
    logic                   sck_s, cs_s, mosi_s, sck_d, rise, fall;
    logic [3:0]             state;
    logic [2:0]             bit_cnt;
    logic [1:0]             byte_cnt, id_idx;
    logic [6:0]             shift_in;
    logic [7:0]             rx_byte, tx_byte, shift_out, prefetch, cmd;
    logic [MEM_AW-2:0]      addr_sr;
    logic [MEM_AW-1:0]      addr, addr_next, addr_inc;
    logic                   oe;
    logic [7:0]             mem [0:(1<<MEM_AW)-1];

`ifdef SPI_FLASH_EMU_PROG_EN
    localparam logic [3:0]        S_PROG    = 4'd8;
    localparam logic [MEM_AW-1:0] PAGE_MASK = MEM_AW'(8'hFF);
    logic                         wel, wren_pend, prog_done, prog_we;
    logic [MEM_AW-1:0]            prog_addr, addr_pinc;
    logic [7:0]                   prog_data;
    assign addr_pinc = (addr & ~PAGE_MASK) | (addr_inc & PAGE_MASK);
`else
    logic wel;
    assign wel = 1'b0;
`endif

    assign sck_s     = sck_sync[SYNC_STAGES-1];
    assign cs_s      = cs_sync[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync[SYNC_STAGES-1];
    assign rise      = sck_s & ~sck_d;
    assign fall      = ~sck_s & sck_d;
    assign rx_byte   = {shift_in, mosi_s};
    // Upper address bits fall off the shift register, giving the modulo wrap for free.
    assign addr_next = {addr_sr, mosi_s};
    assign addr_inc  = addr + MEM_AW'(1);

    always_comb begin
        tx_byte = '0;
        case (state)
            S_DATA: tx_byte = prefetch;
            S_ID: begin
                case (id_idx)
                    2'd0:    tx_byte = JEDEC_ID[23:16];
                    2'd1:    tx_byte = JEDEC_ID[15:8];
                    default: tx_byte = JEDEC_ID[7:0];
                endcase
            end
            S_STAT:  tx_byte = {6'b0, wel, 1'b0};
            default: tx_byte = '0;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sck_sync  <= '0;
            cs_sync   <= '1;
            mosi_sync <= '0;
            sck_d     <= 1'b0;
            state     <= S_IDLE;
            bit_cnt   <= '0;
            byte_cnt  <= '0;
            id_idx    <= '0;
            shift_in  <= '0;
            shift_out <= '0;
            addr_sr   <= '0;
            addr      <= '0;
            prefetch  <= '0;
            cmd       <= '0;
            oe        <= 1'b0;
`ifdef SPI_FLASH_EMU_PROG_EN
            wel       <= 1'b0;
            wren_pend <= 1'b0;
            prog_done <= 1'b0;
            prog_we   <= 1'b0;
            prog_addr <= '0;
            prog_data <= '0;
`endif
        end else begin
            sck_sync  <= {sck_sync[SYNC_STAGES-2:0], bus.spi_sck_i};
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], bus.spi_cs_ni};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], bus.spi_mosi_i};
            sck_d     <= sck_s;
`ifdef SPI_FLASH_EMU_PROG_EN
            prog_we   <= 1'b0;
`endif
            // Deselect has priority over any coincident SCK edge.
            if (cs_s) begin
                state    <= S_IDLE;
                bit_cnt  <= '0;
                byte_cnt <= '0;
                id_idx   <= '0;
                oe       <= 1'b0;
`ifdef SPI_FLASH_EMU_PROG_EN
                if (wren_pend) wel <= 1'b1;
                else if (prog_done) wel <= 1'b0;
                wren_pend <= 1'b0;
                prog_done <= 1'b0;
`endif
            end else if (state == S_IDLE) begin
                state <= S_CMD;
            end else if (rise) begin
                bit_cnt  <= bit_cnt + 3'd1;
                shift_in <= rx_byte[6:0];
                case (state)
                    S_CMD: if (bit_cnt == 3'd7) begin
                        cmd      <= rx_byte;
                        byte_cnt <= '0;
                        case (rx_byte)
                            8'h03, 8'h0B: state <= S_ADDR;
                            8'h9F:        state <= S_ID;
                            8'h05:        state <= S_STAT;
`ifdef SPI_FLASH_EMU_PROG_EN
                            8'h06: begin wren_pend <= 1'b1; state <= S_IGNORE; end
                            8'h04: begin wel <= 1'b0; state <= S_IGNORE; end
                            8'h02:        state <= wel ? S_ADDR : S_IGNORE;
`endif
                            default:      state <= S_IGNORE;
                        endcase
                    end
                    S_ADDR: begin
                        addr_sr <= addr_next[MEM_AW-2:0];
                        if (bit_cnt == 3'd7) byte_cnt <= byte_cnt + 2'd1;
                        if (bit_cnt == 3'd7 && byte_cnt == 2'd2) begin
                            addr     <= addr_next;
                            prefetch <= mem[addr_next];
                            case (cmd)
                                8'h0B:   state <= S_DUMMY;
`ifdef SPI_FLASH_EMU_PROG_EN
                                8'h02:   state <= S_PROG;
`endif
                                default: state <= S_DATA;
                            endcase
                        end
                    end
                    S_DUMMY: if (bit_cnt == 3'd7) state <= S_DATA;
`ifdef SPI_FLASH_EMU_PROG_EN
                    S_PROG: if (bit_cnt == 3'd7) begin
                        prog_we   <= 1'b1;
                        prog_addr <= addr;
                        prog_data <= rx_byte;
                        addr      <= addr_pinc;
                        prog_done <= 1'b1;
                    end
`endif
                    default: ;
                endcase
            end else if (fall && (state == S_DATA || state == S_ID || state == S_STAT)) begin
                // bit_cnt wraps to 0 after each 8th rise, so the next fall starts a new byte.
                if (bit_cnt == 3'd0) begin
                    shift_out <= tx_byte;
                    oe        <= 1'b1;
                    if (state == S_DATA) begin
                        addr     <= addr_inc;
                        prefetch <= mem[addr_inc];
                    end
                    if (state == S_ID) id_idx <= (id_idx == 2'd2) ? 2'd0 : id_idx + 2'd1;
                end else begin
                    shift_out <= {shift_out[6:0], 1'b0};
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (bus.load_we_i) mem[bus.load_addr_i] <= bus.load_data_i;
`ifdef SPI_FLASH_EMU_PROG_EN
        else if (prog_we) mem[prog_addr] <= prog_data;
`endif
    end

    assign bus.spi_miso_o    = oe & shift_out[7];
    assign bus.spi_miso_oe_o = oe;
    assign bus.active_o      = ~cs_s;
    assign bus.last_cmd_o    = cmd;
endmodule

// File: tb/tb_spi_flash_emu.sv
// Self-checking bench for spi_flash_emu: constant vector table, corner sequences, random vs. byte-level model.
module tb_spi_flash_emu;
    localparam int          HALF = 4;
    localparam int          AW   = 12;
    localparam logic [23:0] JID  = 24'hBF2541;
`ifdef SPI_FLASH_EMU_PROG_EN
    localparam bit PROG = 1'b1;
`else
    localparam bit PROG = 1'b0;
`endif

    typedef logic [7:0] barr_t [12];
    typedef struct {
        string       name;
        int          n;
        logic [95:0] tx;
        logic [95:0] rx;
        logic [11:0] oe;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst;
    int         checks = 0;
    int         errors = 0;
    logic [7:0] model_mem [4096];
    logic       model_wel = 1'b0;

    spi_flash_emu_if #(.MEM_AW(AW)) bus ();

    spi_flash_emu #(.MEM_AW(AW), .SYNC_STAGES(2), .JEDEC_ID(JID)) dut (
        .clk_i(clk),
        .rst_i(rst),
        .bus  (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [95:0] pack(input barr_t b);
        logic [95:0] p;
        for (int i = 0; i < 12; i++) p[95-8*i -: 8] = b[i];
        return p;
    endfunction

    function automatic barr_t unpack(input logic [95:0] p);
        barr_t b;
        for (int i = 0; i < 12; i++) b[i] = p[95-8*i -: 8];
        return b;
    endfunction

    // Byte-level flash behaviour: what each clocked byte should return and whether MISO is driven.
    function automatic void model_txn(input int n, input barr_t tx, output barr_t rx, output logic [11:0] oe);
        logic [23:0] a24;
        int unsigned a;
        a24 = {tx[1], tx[2], tx[3]};
        a   = a24 % 4096;
        rx  = '{default: 8'h00};
        oe  = '0;
        case (tx[0])
            8'h03: for (int i = 4; i < n; i++) begin rx[i] = model_mem[(a + i - 4) % 4096]; oe[11-i] = 1'b1; end
            8'h0B: for (int i = 5; i < n; i++) begin rx[i] = model_mem[(a + i - 5) % 4096]; oe[11-i] = 1'b1; end
            8'h9F: for (int i = 1; i < n; i++) begin rx[i] = JID[23-8*((i-1)%3) -: 8]; oe[11-i] = 1'b1; end
            8'h05: for (int i = 1; i < n; i++) begin rx[i] = {6'b0, model_wel, 1'b0}; oe[11-i] = 1'b1; end
            8'h06: if (PROG) model_wel = 1'b1;
            8'h04: if (PROG) model_wel = 1'b0;
            8'h02: if (PROG && model_wel && n > 4) begin
                for (int i = 4; i < n; i++) model_mem[(a & 32'hF00) | ((a + i - 4) & 32'hFF)] = tx[i];
                model_wel = 1'b0;
            end
            default: ;
        endcase
    endfunction

    task automatic load(input logic [11:0] addr, input logic [7:0] data);
        bus.load_we_i   = 1'b1;
        bus.load_addr_i = addr;
        bus.load_data_i = data;
        @(negedge clk);
        bus.load_we_i   = 1'b0;
        model_mem[addr] = data;
    endtask

    task automatic cs_low();
        bus.spi_cs_ni = 1'b0;
        repeat (HALF) @(negedge clk);
    endtask

    task automatic cs_high();
        repeat (HALF) @(negedge clk);
        bus.spi_cs_ni = 1'b1;
        repeat (HALF + 4) @(negedge clk);
    endtask

    task automatic spi_byte(input logic [7:0] b, input int nbits, output logic [7:0] r,
                            output logic all_oe, output logic any_oe);
        r      = '0;
        all_oe = 1'b1;
        any_oe = 1'b0;
        for (int k = 0; k < nbits; k++) begin
            bus.spi_mosi_i = b[7-k];
            repeat (HALF) @(negedge clk);
            r[7-k] = bus.spi_miso_o;
            all_oe = all_oe & bus.spi_miso_oe_o;
            any_oe = any_oe | bus.spi_miso_oe_o;
            bus.spi_sck_i = 1'b1;
            repeat (HALF) @(negedge clk);
            bus.spi_sck_i = 1'b0;
        end
    endtask

    task automatic txn(input int n, input barr_t tx, output barr_t rx,
                       output logic [11:0] oe_all, output logic [11:0] oe_any);
        logic [7:0] r;
        logic       a, o;
        rx     = '{default: 8'h00};
        oe_all = '0;
        oe_any = '0;
        cs_low();
        for (int i = 0; i < n; i++) begin
            spi_byte(tx[i], 8, r, a, o);
            rx[i]        = r;
            oe_all[11-i] = a;
            oe_any[11-i] = o;
        end
        cs_high();
    endtask

    task automatic run_model_check(input string name, input int n, input barr_t tx, output barr_t rx);
        barr_t       exp_rx;
        logic [11:0] exp_oe, oa, ob;
        model_txn(n, tx, exp_rx, exp_oe);
        txn(n, tx, rx, oa, ob);
        chk({name, "_rx"}, pack(rx), pack(exp_rx));
        chk({name, "_oe"}, {oa, ob}, {exp_oe, exp_oe});
        chk({name, "_cmd"}, bus.last_cmd_o, tx[0]);
    endtask

    initial begin
        #5_000_000;
        errors++;
        $display("FAIL watchdog: got timeout, expected completion");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t        vecs[6];
        barr_t       tx, rx;
        logic [11:0] oa, ob;
        logic [7:0]  r;
        logic        a, o;

        vecs[0] = '{"read",      8, 96'h03000010_00000000_00000000, 96'h00000000_DEADBEEF_00000000, 12'b0000_1111_0000};
        vecs[1] = '{"fast_wrap", 7, 96'h0B7FFFFF_00000000_00000000, 96'h00000000_005AA500_00000000, 12'b0000_0110_0000};
        vecs[2] = '{"jedec",     7, 96'h9F000000_00000000_00000000, 96'h00BF2541_BF254100_00000000, 12'b0111_1110_0000};
        vecs[3] = '{"rdsr",      3, 96'h05000000_00000000_00000000, 96'h00000000_00000000_00000000, 12'b0110_0000_0000};
        vecs[4] = '{"unknown",   2, 96'hAB000000_00000000_00000000, 96'h00000000_00000000_00000000, 12'b0000_0000_0000};
        vecs[5] = '{"read_wrap", 6, 96'h03FFFFFF_00000000_00000000, 96'h00000000_5AA50000_00000000, 12'b0000_1100_0000};

        rst             = 1'b1;
        bus.spi_sck_i   = 1'b0;
        bus.spi_cs_ni   = 1'b1;
        bus.spi_mosi_i  = 1'b0;
        bus.load_we_i   = 1'b0;
        bus.load_addr_i = '0;
        bus.load_data_i = '0;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_miso", bus.spi_miso_o, 1'b0);
        chk("reset_oe", bus.spi_miso_oe_o, 1'b0);
        chk("reset_active", bus.active_o, 1'b0);
        chk("reset_last_cmd", bus.last_cmd_o, 8'h00);

        for (int i = 0; i < 4096; i++) load(12'(i), 8'((i * 7 + 3) & 255));
        load(12'h010, 8'hDE);
        load(12'h011, 8'hAD);
        load(12'h012, 8'hBE);
        load(12'h013, 8'hEF);
        load(12'hFFF, 8'h5A);
        load(12'h000, 8'hA5);

        for (int v = 0; v < 6; v++) begin
            txn(vecs[v].n, unpack(vecs[v].tx), rx, oa, ob);
            chk({vecs[v].name, "_rx"}, pack(rx), vecs[v].rx);
            chk({vecs[v].name, "_oe"}, {oa, ob}, {vecs[v].oe, vecs[v].oe});
            chk({vecs[v].name, "_cmd"}, bus.last_cmd_o, vecs[v].tx[95:88]);
        end

        // Abort during the address phase, then a clean read.
        cs_low();
        spi_byte(8'h03, 8, r, a, o);
        spi_byte(8'h00, 4, r, a, o);
        cs_high();
        tx = unpack(96'h03000010_00000000_00000000);
        txn(5, tx, rx, oa, ob);
        chk("abort_then_read", rx[4], 8'hDE);

        // Write-enable and page program across the 0x1FF -> 0x100 page wrap.
        load(12'h1FE, 8'hC1);
        load(12'h1FF, 8'hC2);
        load(12'h100, 8'hC3);
        load(12'h200, 8'hC4);
        run_model_check("wren", 1, unpack(96'h06000000_00000000_00000000), rx);
        run_model_check("rdsr_wel", 2, unpack(96'h05000000_00000000_00000000), rx);
        chk("rdsr_wel_value", rx[1], PROG ? 8'h02 : 8'h00);
        run_model_check("pp", 7, unpack(96'h020001FE_112233_00_00000000), rx);
        run_model_check("rdsr_after_pp", 2, unpack(96'h05000000_00000000_00000000), rx);
        run_model_check("pp_read_1fe", 7, unpack(96'h030001FE_00000000_00000000), rx);
        chk("pp_mem_1fe", rx[4], PROG ? 8'h11 : 8'hC1);
        run_model_check("pp_read_100", 5, unpack(96'h03000100_00000000_00000000), rx);
        chk("pp_mem_100", rx[4], PROG ? 8'h33 : 8'hC3);

        // Reset asserted while streaming data.
        cs_low();
        tx = unpack(96'h03000010_00000000_00000000);
        for (int i = 0; i < 4; i++) spi_byte(tx[i], 8, r, a, o);
        spi_byte(8'h00, 4, r, a, o);
        chk("mid_active", bus.active_o, 1'b1);
        chk("mid_oe_before_rst", bus.spi_miso_oe_o, 1'b1);
        rst = 1'b1;
        #1;
        chk("mid_rst_miso", bus.spi_miso_o, 1'b0);
        chk("mid_rst_oe", bus.spi_miso_oe_o, 1'b0);
        chk("mid_rst_last_cmd", bus.last_cmd_o, 8'h00);
        @(negedge clk);
        bus.spi_cs_ni = 1'b1;
        repeat (4) @(negedge clk);
        rst       = 1'b0;
        model_wel = 1'b0;
        repeat (4) @(negedge clk);
        run_model_check("after_rst_read", 6, tx, rx);

        for (int it = 0; it < 30; it++) begin
            int          op, n;
            logic [11:0] la;
            op = int'($urandom_range(0, 5));
            for (int k = 0; k < 12; k++) tx[k] = 8'($urandom);
            n = 1;
            case (op)
                0: begin
                    la = 12'($urandom);
                    for (int k = 0; k < 3; k++) load(la + 12'(k), 8'($urandom));
                    tx[0] = 8'h03;
                    tx[2] = {tx[2][7:4], la[11:8]};
                    tx[3] = la[7:0];
                    n = 7;
                end
                1: begin tx[0] = 8'h03; n = 4 + int'($urandom_range(1, 4)); end
                2: begin tx[0] = 8'h0B; n = 5 + int'($urandom_range(1, 4)); end
                3: begin tx[0] = 8'h9F; n = 1 + int'($urandom_range(1, 6)); end
                4: begin tx[0] = 8'h05; n = 1 + int'($urandom_range(1, 2)); end
                default: begin
                    case ($urandom_range(0, 3))
                        0: tx[0] = 8'hAB;
                        1: tx[0] = 8'h00;
                        2: tx[0] = 8'hFF;
                        default: tx[0] = 8'h5A;
                    endcase
                    n = 1 + int'($urandom_range(0, 2));
                end
            endcase
            run_model_check($sformatf("rand%0d", it), n, tx, rx);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/spi_flash_emu.md
Name: spi_flash_emu

Overview:
Parametrised, synthesisable SPI NOR-flash emulator that stands in for the external boot flash on the SoC SPI pins (spi_cs_n / spi_sck / spi_mosi / spi_miso).
- All SPI inputs are oversampled in the clk_i domain; no SCK-clocked logic.
- Generalises the fixed-size behavioural flash model to configurable depth, JEDEC ID and command set.
- Memory is preloaded through a backdoor load port, so the same block serves simulation and on-FPGA boot bring-up.

Parameters:
MEM_AW, 12, log2 of memory depth in bytes (4 KiB default)
SYNC_STAGES, 2, synchroniser flops on sck, cs_n and mosi (minimum 2)
JEDEC_ID, 24'hBF2541, 3-byte ID returned by command 0x9F, MSB first

Ports:
clk_i  in  1  system clock; all logic on rising edge
rst_i  in  1  asynchronous, active-high reset
spi_sck_i  in  1  SPI clock, mode 0; clk_i frequency >= 2*(SYNC_STAGES+1) * sck frequency
spi_cs_ni  in  1  chip select, active low
spi_mosi_i  in  1  serial data in
spi_miso_o  out  1  serial data out; 0 when not driving
spi_miso_oe_o  out  1  high while driving a response phase
load_we_i  in  1  backdoor byte write strobe
load_addr_i  in  MEM_AW  backdoor write address
load_data_i  in  8  backdoor write data
active_o  out  1  synchronised CS asserted
last_cmd_o  out  8  opcode of the most recently completed command byte

Behaviour:
- Reset: spi_miso_o=0, spi_miso_oe_o=0, active_o=0, last_cmd_o=8'h00, FSM=IDLE, all counters 0, WEL=0. Memory contents are not reset.
- Synchronisation: sck, cs_n and mosi each pass through SYNC_STAGES flops. Edges are detected on the synchronised sck.
  - rise: sample mosi into shift-in register, increment bit_cnt (3 bits).
  - fall: shift the next miso bit out, MSB first.
- CS handling: synced cs_n high forces FSM to IDLE in the same cycle it is seen, clears spi_miso_oe_o and spi_miso_o, and resets bit_cnt. This applies from any state, mid-byte included; a partial byte is discarded.
- States:
  - IDLE -> CMD on synced cs_n falling.
  - CMD: after 8 rises, latch last_cmd_o, then dispatch:
    - 0x03 -> ADDR
    - 0x0B -> ADDR (then DUMMY)
    - 0x9F -> ID
    - 0x05 -> STAT
    - other -> IGNORE
  - ADDR: 24 bits MSB first. Only the low MEM_AW bits are kept (modulo wrap); upper bits are ignored.
    - On the 24th rise, issue the synchronous memory read at addr.
    - Next state: DATA for 0x03; DUMMY for 0x0B.
  - DUMMY: 8 rises with mosi ignored, then DATA.
  - DATA: on the fall after entering DATA, load the shift-out register from the prefetch register and assert spi_miso_oe_o.
    - Each time a byte is loaded, increment addr mod 2^MEM_AW and prefetch mem[addr+1] (1-cycle read latency, hidden by the oversampling ratio).
    - The stream is endless until CS high; it wraps from 2^MEM_AW-1 to 0.
  - ID: stream JEDEC_ID[23:16], [15:8], [7:0], then repeat from [23:16].
  - STAT: stream status byte {6'b0, WEL, BUSY} repeatedly. BUSY is always 0.
  - IGNORE: spi_miso_oe_o=0 until CS high.
- Load port:
  - load_we_i writes mem[load_addr_i] in the same cycle, at any time.
  - A load to the address currently being prefetched does not update the prefetch register; the host loads only while active_o=0.
- Simultaneous synced cs_n rise and sck edge in one cycle: the CS rise wins; the edge is ignored.

Optional Feature:
Macro SPI_FLASH_EMU_PROG_EN.
- Defined, the following commands are supported:
  - 0x06 WREN: sets WEL on CS rise.
  - 0x04 WRDI: clears WEL.
  - 0x02 PAGE PROGRAM (only if WEL=1, otherwise -> IGNORE): 24-bit address, then each received byte is written to mem.
    - Address increments within the 256-byte page: low 8 bits wrap, upper bits are held.
    - On CS rise after at least 1 data byte, WEL clears.
  - If load_we_i and a program write hit the same cycle, load_we_i wins.
- Not defined: 0x06, 0x04 and 0x02 go to IGNORE, and WEL is constant 0.

Test Plan:
- Reset mid-stream: assert rst_i during a DATA phase -> spi_miso_o=0, spi_miso_oe_o=0, last_cmd_o=8'h00 immediately; after release, the next command decodes normally.
- READ: preload mem[0x010..0x013]=DE AD BE EF; send 03 00 00 10 then clock 32 bits -> MISO bytes DE AD BE EF; last_cmd_o=8'h03.
- Wrap and FAST READ: preload mem[0xFFF]=0x5A, mem[0x000]=0xA5; send 0B 7F FF FF plus dummy byte -> MISO 5A then A5 (upper address bits ignored).
- JEDEC ID: send 9F, clock 48 bits -> BF 25 41 BF 25 41; send 05 -> 00.
- Abort and unknown: raise CS after 4 bits of the address phase, then send 03 00 00 10 -> first byte DE. Send AB, clock 8 bits -> spi_miso_oe_o stays 0.
- With SPI_FLASH_EMU_PROG_EN: send 06 (CS cycle), then 05 -> 02. Send 02 00 01 FE + 11 22 33 -> mem[0x1FE]=11, mem[0x1FF]=22, mem[0x100]=33; then 05 -> 00. Without the macro: same sequence leaves memory unchanged.
